// File: rtl/alu_arbiter_pkg.sv
// Shared opcode encodings and request payload type for the execute-stage ALU arbiter.
package alu_arbiter_pkg;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_SLT    = 4'b0010;
   localparam logic [3:0] ALU_SLTU   = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_OR     = 4'b0101;
   localparam logic [3:0] ALU_AND    = 4'b0110;
   localparam logic [3:0] ALU_SLL    = 4'b0111;
   localparam logic [3:0] ALU_SRL    = 4'b1000;
   localparam logic [3:0] ALU_SRA    = 4'b1001;
   localparam logic [3:0] ALU_PASS_B = 4'b1111;

   typedef struct packed {
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      logic [3:0]  alu_op;
   } alu_req_t;

   // Encodings 1010..1110 are holes in the opcode map.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= ALU_SRA) || (op == ALU_PASS_B);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of both request channels, the ALU drive/return and the response channel.
interface alu_arbiter_if #(
   parameter int TAG_W = 4
);

   logic             i_req0_valid;
   logic             o_req0_ready;
   logic [31:0]      i_req0_operand_a;
   logic [31:0]      i_req0_operand_b;
   logic [3:0]       i_req0_alu_op;
   logic [TAG_W-1:0] i_req0_tag;

   logic             i_req1_valid;
   logic             o_req1_ready;
   logic [31:0]      i_req1_operand_a;
   logic [31:0]      i_req1_operand_b;
   logic [3:0]       i_req1_alu_op;
   logic [TAG_W-1:0] i_req1_tag;

   logic [31:0]      o_alu_operand_a;
   logic [31:0]      o_alu_operand_b;
   logic [3:0]       o_alu_op;
   logic [31:0]      i_alu_data;

   logic             o_rsp_valid;
   logic             i_rsp_ready;
   logic [31:0]      o_rsp_data;
   logic             o_rsp_id;
   logic [TAG_W-1:0] o_rsp_tag;
   logic             o_rsp_illegal;

   modport master (
      output i_req0_valid, i_req0_operand_a, i_req0_operand_b, i_req0_alu_op, i_req0_tag,
      input  o_req0_ready,
      output i_req1_valid, i_req1_operand_a, i_req1_operand_b, i_req1_alu_op, i_req1_tag,
      input  o_req1_ready,
      input  o_alu_operand_a, o_alu_operand_b, o_alu_op,
      output i_alu_data,
      input  o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_tag, o_rsp_illegal,
      output i_rsp_ready
   );

   modport slave (
      input  i_req0_valid, i_req0_operand_a, i_req0_operand_b, i_req0_alu_op, i_req0_tag,
      output o_req0_ready,
      input  i_req1_valid, i_req1_operand_a, i_req1_operand_b, i_req1_alu_op, i_req1_tag,
      output o_req1_ready,
      output o_alu_operand_a, o_alu_operand_b, o_alu_op,
      input  i_alu_data,
      output o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_tag, o_rsp_illegal,
      input  i_rsp_ready
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant: a lone requester always wins; on a tie the priority pointer
// decides (round-robin) or requester 0 wins (fixed priority).
module rr_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic       o_gnt_valid,
   output logic       o_gnt_id
);

   logic r_prio;

   always_comb begin
      o_gnt_valid = |i_req;
      o_gnt_id    = 1'b0;
      if (i_req == 2'b10) begin
         o_gnt_id = 1'b1;
      end else if ((i_req == 2'b11) && RR_EN) begin
         o_gnt_id = r_prio;
      end
   end

   // After every accepted grant the other requester gets first claim on a tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prio <= 1'b0;
      end else if (i_advance && RR_EN) begin
         r_prio <= ~o_gnt_id;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and returns
// each result through a one-entry response buffer tagged with requester ID.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter bit RR_EN = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   alu_arbiter_if.slave bus
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       r_state;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_id;
   logic [TAG_W-1:0] r_rsp_tag;
   logic             r_rsp_illegal;

   logic             w_free;
   logic             w_gnt_valid;
   logic             w_gnt_id;
   logic             w_accept;
   alu_req_t         w_sel;
   logic [TAG_W-1:0] w_sel_tag;

   // Draining the buffer frees it in the same cycle, so back-to-back ops never bubble.
   assign w_free = (r_state == ST_EMPTY) | bus.i_rsp_ready;

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       ({bus.i_req1_valid, bus.i_req0_valid}),
      .i_advance   (w_accept),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   assign bus.o_req0_ready = ~i_rst & w_free & w_gnt_valid & ~w_gnt_id;
   assign bus.o_req1_ready = ~i_rst & w_free & w_gnt_valid &  w_gnt_id;
   assign w_accept         = bus.o_req0_ready | bus.o_req1_ready;

   // ALU inputs sit at zero (ADD) when idle or in reset to keep them quiet.
   always_comb begin
      w_sel     = '0;
      w_sel_tag = '0;
      if (!i_rst && w_gnt_valid) begin
         if (w_gnt_id) begin
            w_sel.operand_a = bus.i_req1_operand_a;
            w_sel.operand_b = bus.i_req1_operand_b;
            w_sel.alu_op    = bus.i_req1_alu_op;
            w_sel_tag       = bus.i_req1_tag;
         end else begin
            w_sel.operand_a = bus.i_req0_operand_a;
            w_sel.operand_b = bus.i_req0_operand_b;
            w_sel.alu_op    = bus.i_req0_alu_op;
            w_sel_tag       = bus.i_req0_tag;
         end
      end
   end

   assign bus.o_alu_operand_a = w_sel.operand_a;
   assign bus.o_alu_operand_b = w_sel.operand_b;
   assign bus.o_alu_op        = w_sel.alu_op;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_EMPTY;
         r_rsp_data    <= '0;
         r_rsp_id      <= 1'b0;
         r_rsp_tag     <= '0;
         r_rsp_illegal <= 1'b0;
      end else if (w_accept) begin
         r_state       <= ST_FULL;
         r_rsp_data    <= bus.i_alu_data;
         r_rsp_id      <= w_gnt_id;
         r_rsp_tag     <= w_sel_tag;
         r_rsp_illegal <= ~is_legal_op(w_sel.alu_op);
      end else if (bus.i_rsp_ready) begin
         r_state       <= ST_EMPTY;
      end
   end

   assign bus.o_rsp_valid   = (r_state == ST_FULL);
   assign bus.o_rsp_data    = r_rsp_data;
   assign bus.o_rsp_id      = r_rsp_id;
   assign bus.o_rsp_tag     = r_rsp_tag;
   assign bus.o_rsp_illegal = r_rsp_illegal;

endmodule
